if_else_demod_298: RTL and testbench

IF_ELSE_DEMOD_298 -- requirements
Module: if_else_demod_298

---
 rtl/if_else_demod_298.sv | 117 +++++++++++
 tb/tb_if_else_demod_298.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/if_else_demod_298.sv
// If/else segment demodulator: picks the nearer reference per segment
// and packs decisions LSB-first into an NBITS-wide word with tie count.
module if_else_demod_298 #(
  parameter int NBITS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        seg_valid,
  output logic        seg_ready,
  input  logic [31:0] segment_in,
  input  logic [31:0] array_ref_wire,
  input  logic [31:0] array_ref_m_wire,
  output logic [31:0] bit_word,
  output logic        word_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic [5:0]  tie_count
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    HOLD
  } state_e;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [31:0] word_q;
  logic [5:0]  tie_q;
  logic        seg_ready_q;
  logic        word_valid_q;
  logic        busy_q;

  logic [5:0]  dist_if_d;
  logic [5:0]  dist_else_d;
  logic        dec_d;
  logic        tie_d;
  logic        last_d;

  function automatic logic [5:0] popcnt(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      c = c + 6'(v[i]);
    end
    return c;
  endfunction

  assign dist_if_d   = popcnt(segment_in ^ array_ref_wire);
  assign dist_else_d = popcnt(segment_in ^ array_ref_m_wire);
  // Ties go to the if-section, mirroring the modulator's priority
  assign dec_d  = (dist_if_d <= dist_else_d);
  assign tie_d  = (dist_if_d == dist_else_d);
  assign last_d = (cnt_q == 5'(NBITS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      word_q       <= '0;
      tie_q        <= '0;
      seg_ready_q  <= 1'b0;
      word_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= COLLECT;
            cnt_q       <= '0;
            word_q      <= '0;
            tie_q       <= '0;
            seg_ready_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        COLLECT: begin
          if (seg_valid) begin
            word_q <= word_q | (32'(dec_d) << cnt_q);
            if (tie_d && (tie_q != 6'd63)) begin
              tie_q <= tie_q + 6'd1;
            end
            if (last_d) begin
              state_q      <= HOLD;
              cnt_q        <= '0;
              seg_ready_q  <= 1'b0;
              word_valid_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 5'd1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q      <= IDLE;
            word_valid_q <= 1'b0;
            busy_q       <= 1'b0;
          end
        end
        default: begin
          state_q      <= IDLE;
          seg_ready_q  <= 1'b0;
          word_valid_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign seg_ready  = seg_ready_q;
  assign word_valid = word_valid_q;
  assign busy       = busy_q;
  assign bit_word   = word_q;
  assign tie_count  = tie_q;

endmodule

// File: tb/tb_if_else_demod_298.sv
// Directed bench for if_else_demod_298 with NBITS = 32, 4 and 8
// instances sharing data inputs and using separate start strobes.
module tb_if_else_demod_298;

  logic        clk = 1'b0;
  logic        reset;
  logic        seg_valid;
  logic        out_ready;
  logic [31:0] seg;
  logic [31:0] ref_if;
  logic [31:0] ref_m;
  logic        st32, st4, st8;

  logic        rdy32, rdy4, rdy8;
  logic        wv32, wv4, wv8;
  logic        bz32, bz4, bz8;
  logic [31:0] bw32, bw4, bw8;
  logic [5:0]  tc32, tc4, tc8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  if_else_demod_298 #(.NBITS(32)) u32 (
    .clk(clk), .reset(reset), .start(st32),
    .seg_valid(seg_valid), .seg_ready(rdy32),
    .segment_in(seg), .array_ref_wire(ref_if),
    .array_ref_m_wire(ref_m), .bit_word(bw32),
    .word_valid(wv32), .out_ready(out_ready),
    .busy(bz32), .tie_count(tc32)
  );

  if_else_demod_298 #(.NBITS(4)) u4 (
    .clk(clk), .reset(reset), .start(st4),
    .seg_valid(seg_valid), .seg_ready(rdy4),
    .segment_in(seg), .array_ref_wire(ref_if),
    .array_ref_m_wire(ref_m), .bit_word(bw4),
    .word_valid(wv4), .out_ready(out_ready),
    .busy(bz4), .tie_count(tc4)
  );

  if_else_demod_298 #(.NBITS(8)) u8 (
    .clk(clk), .reset(reset), .start(st8),
    .seg_valid(seg_valid), .seg_ready(rdy8),
    .segment_in(seg), .array_ref_wire(ref_if),
    .array_ref_m_wire(ref_m), .bit_word(bw8),
    .word_valid(wv8), .out_ready(out_ready),
    .busy(bz8), .tie_count(tc8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    seg_valid = 1'b0;
    out_ready = 1'b0;
    seg = '0;
    ref_if = '0;
    ref_m = '0;
    st32 = 1'b0; st4 = 1'b0; st8 = 1'b0;
    tick();
    tick();
    chk("rst_rdy32", 32'(rdy32), 0);
    chk("rst_wv32", 32'(wv32), 0);
    chk("rst_busy32", 32'(bz32), 0);
    chk("rst_bw32", bw32, 0);
    chk("rst_tc32", 32'(tc32), 0);
    reset = 1'b0;
    tick();
    chk("idle_busy32", 32'(bz32), 0);

    // 32-bit alternating word
    ref_if = 32'hFFFF0000;
    ref_m  = 32'h0000FFFF;
    st32 = 1'b1;
    tick();
    st32 = 1'b0;
    chk("t1_rdy", 32'(rdy32), 1);
    chk("t1_busy", 32'(bz32), 1);
    for (int i = 0; i < 32; i++) begin
      seg = (i % 2 == 0) ? ref_if : ref_m;
      seg_valid = 1'b1;
      tick();
      if (i == 30) chk("t1_wv_early", 32'(wv32), 0);
    end
    chk("t1_wv", 32'(wv32), 1);
    chk("t1_bw", bw32, 32'h55555555);
    chk("t1_tc", 32'(tc32), 0);
    chk("t1_rdy_hold", 32'(rdy32), 0);

    // HOLD stalls with start and segments offered
    seg = ref_if;
    for (int i = 0; i < 10; i++) begin
      st32 = (i == 3);
      tick();
    end
    st32 = 1'b0;
    chk("t2_wv", 32'(wv32), 1);
    chk("t2_bw", bw32, 32'h55555555);
    chk("t2_rdy", 32'(rdy32), 0);
    chk("t2_tc", 32'(tc32), 0);
    seg_valid = 1'b0;
    out_ready = 1'b1;
    st32 = 1'b1;
    tick();
    st32 = 1'b0;
    out_ready = 1'b0;
    chk("t2_wv_drop", 32'(wv32), 0);
    chk("t2_idle", 32'(bz32), 0);
    tick();
    chk("t2_noqueue", 32'(bz32), 0);
    chk("t2_retain", bw32, 32'h55555555);

    // NBITS=4, every segment a tie
    ref_if = 32'hFFFFFFFF;
    ref_m  = 32'h00000000;
    st4 = 1'b1;
    tick();
    st4 = 1'b0;
    seg = 32'h0000FFFF;
    seg_valid = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    seg_valid = 1'b0;
    chk("t3_wv", 32'(wv4), 1);
    chk("t3_bw", bw4, 32'h0000000F);
    chk("t3_tc", 32'(tc4), 4);
    chk("t3_u32_idle", bw32, 32'h55555555);

    // NBITS=8, valid every other cycle
    ref_m  = 32'h12345678;
    ref_if = ~32'h12345678;
    seg = 32'h12345678 ^ 32'h00000107;
    st8 = 1'b1;
    tick();
    st8 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      seg_valid = (i % 2 == 0);
      tick();
      if (i == 13) begin
        chk("t4_wv_early", 32'(wv8), 0);
        chk("t4_rdy_mid", 32'(rdy8), 1);
      end
    end
    chk("t4_wv", 32'(wv8), 1);
    chk("t4_bw", bw8, 32'h00000000);
    chk("t4_tc", 32'(tc8), 0);
    seg = ref_if;
    seg_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    seg_valid = 1'b0;
    chk("t4_noextra", bw8, 32'h00000000);
    chk("t4_u4_hold", bw4, 32'h0000000F);

    // reset after 5 accepts of a 32-bit word
    ref_if = 32'hFFFF0000;
    ref_m  = 32'h0000FFFF;
    st32 = 1'b1;
    tick();
    st32 = 1'b0;
    seg = ref_if;
    seg_valid = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    seg_valid = 1'b0;
    chk("t5_part", bw32, 32'h0000001F);
    #1;
    reset = 1'b1;
    #1;
    chk("t5_async_bw", bw32, 0);
    chk("t5_async_busy", 32'(bz32), 0);
    chk("t5_async_rdy", 32'(rdy32), 0);
    chk("t5_u4_wv", 32'(wv4), 0);
    chk("t5_u4_tc", 32'(tc4), 0);
    chk("t5_u8_wv", 32'(wv8), 0);
    tick();
    reset = 1'b0;
    tick();
    chk("t5_idle", 32'(bz32), 0);
    st32 = 1'b1;
    tick();
    st32 = 1'b0;
    seg_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      seg = (i < 16) ? ref_m : ref_if;
      tick();
    end
    seg_valid = 1'b0;
    chk("t5_wv", 32'(wv32), 1);
    chk("t5_bw", bw32, 32'hFFFF0000);
    chk("t5_tc", 32'(tc32), 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t5_done", 32'(bz32), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
